// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the nibble-serial carry-look-ahead adder.
//   NIBBLE_W        : width of the time-shared CLA slice
//   cla_seq_state_t : sequencer states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package cla_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cla_seq_state_t;

endpackage : cla_seq_pkg

// File: rtl/cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-look-ahead adder. Every carry is written
// as a flat sum of products of generate/propagate terms so no carry depends
// on a previously computed carry.
// Ports:
//   a, b   [3:0] in  : operand nibbles
//   cin          in  : carry into bit 0
//   sum    [3:0] out : a + b + cin (low 4 bits)
//   cout         out : carry out of bit 3
//   c3           out : carry into bit 3 (used for signed overflow)
// ---------------------------------------------------------------------------
module cla4_slice
   import cla_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout,
   output logic                c3
);

   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic                c1;
   logic                c2;

   assign p = a ^ b;
   assign g = a & b;

   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ {c3, c2, c1, cin};

endmodule : cla4_slice

// File: rtl/cla_nibble_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_seq_adder
// Adds two WIDTH-bit operands by pushing them through a single 4-bit CLA
// slice one nibble per clock, LSB nibble first. The carry between nibbles
// lives in a register. Result appears NIBBLES cycles after the accept edge.
//
// Optional build macro: CLA_SEQ_OVERFLOW_FLAG_EN adds the 'ovf' output
// (two's-complement signed overflow, valid with out_valid).
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   in_valid/ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin       : operands and carry into the LSB
//   out_valid/ready : result handshake
//   sum, cout       : registered result and carry out of the MSB
//   busy            : high while in RUN or DONE
//   ovf             : signed overflow (only with CLA_SEQ_OVERFLOW_FLAG_EN)
// ---------------------------------------------------------------------------
module cla_nibble_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
         $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   cla_seq_state_t      state;
   logic [IDX_W-1:0]    idx;
   logic                carry;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;

   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                slice_c3;

   cla4_slice u_slice (
      .a    (a_reg[NIBBLE_W-1:0]),
      .b    (b_reg[NIBBLE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

`ifndef CLA_SEQ_OVERFLOW_FLAG_EN
   // c3 only feeds the overflow flag, which this build omits.
   logic unused_c3;
   assign unused_c3 = slice_c3;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= a;
                  b_reg    <= b;
                  carry    <= cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end

            RUN: begin
               sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
               carry <= slice_cout;
               a_reg <= a_reg >> NIBBLE_W;
               b_reg <= b_reg >> NIBBLE_W;
               idx   <= idx + 1'b1;
               if (idx == IDX_W'(NIBBLES - 1)) begin
                  cout      <= slice_cout;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
                  // Carry into the MSB differs from carry out of it.
                  ovf       <= slice_c3 ^ slice_cout;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               // in_ready stays low here, so a new operand is only taken
               // the cycle after the result handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule : cla_nibble_seq_adder
